// File: rtl/tone_decoder.sv
// Square-wave tone decoder: measures the period of a one-bit tone input,
// locks after two consistent periods and reports half-period ticks.
module tone_decoder #(
  parameter int unsigned WIDTH      = 18,
  parameter int unsigned TOL        = 2,
  parameter int unsigned MIN_PERIOD = 4,
  parameter int unsigned TIMEOUT    = 400000
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             sound_in,
  output logic [WIDTH-1:0] ticks,
  output logic             silent,
  output logic             note_valid
);

  localparam int unsigned CW = WIDTH + 1;
  localparam logic [CW-1:0] CNT_MAX = {CW{1'b1}};

  typedef enum logic [1:0] {
    S_SILENT,
    S_ARM,
    S_CONFIRM,
    S_LOCKED
  } state_e;

  state_e            state_q;
  logic              meta_q;
  logic              sync_q;
  logic              prev_q;
  logic              rise_q;
  logic [CW-1:0]     cnt_q;
  logic [CW-1:0]     cnt_d;
  logic [CW-1:0]     cand_q;
  logic [CW-1:0]     diff_c;
  logic [WIDTH-1:0]  half_c;
  logic [WIDTH-1:0]  ticks_q;
  logic              silent_q;
  logic              note_valid_q;
  logic              accept_c;
  logic              match_c;
  logic              timeout_c;
  logic              arm_rise_c;

  // Two-flop synchronizer, delay stage and registered rising-edge flag.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      prev_q <= 1'b0;
      rise_q <= 1'b0;
    end else begin
      meta_q <= sound_in;
      sync_q <= meta_q;
      prev_q <= sync_q;
      rise_q <= sync_q & ~prev_q;
    end
  end

  always_comb begin
    arm_rise_c = rise_q && (state_q == S_SILENT);
    accept_c   = rise_q && (cnt_q >= CW'(MIN_PERIOD));
    diff_c     = (cnt_q >= cand_q) ? (cnt_q - cand_q) : (cand_q - cnt_q);
    match_c    = (diff_c <= CW'(TOL));
    timeout_c  = (state_q != S_SILENT) && !accept_c && (cnt_q == CW'(TIMEOUT));
    half_c     = cnt_q[WIDTH:1];
  end

  // Period counter: cleared on arming, restarted on accepted rises, saturating.
  always_comb begin
    cnt_d = cnt_q;
    if (arm_rise_c) begin
      cnt_d = '0;
    end else if (accept_c) begin
      cnt_d = CW'(1);
    end else if (cnt_q != CNT_MAX) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Lock FSM; the strobe fires only when the reported note actually changes.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_q      <= S_SILENT;
      cand_q       <= '0;
      ticks_q      <= '0;
      silent_q     <= 1'b1;
      note_valid_q <= 1'b0;
    end else begin
      note_valid_q <= 1'b0;
      if (timeout_c) begin
        state_q      <= S_SILENT;
        ticks_q      <= '0;
        silent_q     <= 1'b1;
        note_valid_q <= ~silent_q;
      end else if (arm_rise_c) begin
        state_q <= S_ARM;
      end else if (accept_c) begin
        unique case (state_q)
          S_ARM: begin
            cand_q  <= cnt_q;
            state_q <= S_CONFIRM;
          end
          S_CONFIRM: begin
            if (match_c) begin
              state_q      <= S_LOCKED;
              ticks_q      <= half_c;
              silent_q     <= 1'b0;
              note_valid_q <= silent_q || (half_c != ticks_q);
            end else begin
              cand_q <= cnt_q;
            end
          end
          S_LOCKED: begin
            if (!match_c) begin
              cand_q  <= cnt_q;
              state_q <= S_CONFIRM;
            end
          end
          default: begin
            state_q <= state_q;
          end
        endcase
      end
    end
  end

  assign ticks      = ticks_q;
  assign silent     = silent_q;
  assign note_valid = note_valid_q;

endmodule

// File: tb/tb_tone_decoder.sv
// Directed bench for tone_decoder: one instance with a short silence timeout,
// one with the long default timeout for the wide-period boundary case.
module tb_tone_decoder;

  logic        clk = 1'b0;
  logic        clr;
  logic        sound_in;
  logic [17:0] ticks_a;
  logic        silent_a;
  logic        nv_a;
  logic [17:0] ticks_b;
  logic        silent_b;
  logic        nv_b;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_rise_cyc = 0;
  int last_nv_cyc = 0;
  int nv_cnt = 0;
  logic prev_nv_a = 1'b0;

  tone_decoder #(.WIDTH(18), .TOL(2), .MIN_PERIOD(4), .TIMEOUT(200)) u_dut_a (
    .clk(clk), .clr(clr), .sound_in(sound_in),
    .ticks(ticks_a), .silent(silent_a), .note_valid(nv_a)
  );

  tone_decoder #(.WIDTH(18), .TOL(2), .MIN_PERIOD(4), .TIMEOUT(400000)) u_dut_b (
    .clk(clk), .clr(clr), .sound_in(sound_in),
    .ticks(ticks_b), .silent(silent_b), .note_valid(nv_b)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Strobe monitor on instance A: counts pulses, records when, checks width.
  always @(negedge clk) begin
    if (nv_a === 1'b1) begin
      check("nv_one_cycle", 32'(prev_nv_a), 32'd0);
      nv_cnt++;
      last_nv_cyc = cyc;
    end
    prev_nv_a = nv_a;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wave(input int hi, input int lo, input int n);
    for (int i = 0; i < n; i++) begin
      sound_in = 1'b1;
      last_rise_cyc = cyc;
      tick(hi);
      sound_in = 1'b0;
      tick(lo);
    end
  endtask

  // P=40 period with a short low dip just after the rise (glitch rise at P=3).
  task automatic wave_glitch_early();
    sound_in = 1'b1;
    last_rise_cyc = cyc;
    tick(2);
    sound_in = 1'b0;
    tick(1);
    sound_in = 1'b1;
    tick(17);
    sound_in = 1'b0;
    tick(20);
  endtask

  // P=40 period with a one-clock high spike in the middle of the low half.
  task automatic wave_glitch_mid();
    sound_in = 1'b1;
    last_rise_cyc = cyc;
    tick(20);
    sound_in = 1'b0;
    tick(9);
    sound_in = 1'b1;
    tick(1);
    sound_in = 1'b0;
    tick(10);
  endtask

  initial begin
    clr = 1'b0;
    sound_in = 1'b0;
    tick(3);
    check("rst_ticks", 32'(ticks_a), 32'd0);
    check("rst_silent", 32'(silent_a), 32'd1);
    check("rst_nv", 32'(nv_a), 32'd0);
    check("rst_ticks_b", 32'(ticks_b), 32'd0);
    clr = 1'b1;
    tick(3);

    // Basic lock at P=20
    wave(10, 10, 2);
    check("pre_lock_nv", 32'(nv_cnt), 32'd0);
    check("pre_lock_silent", 32'(silent_a), 32'd1);
    wave(10, 10, 1);
    check("lock_ticks", 32'(ticks_a), 32'd10);
    check("lock_silent", 32'(silent_a), 32'd0);
    check("lock_nv_cnt", 32'(nv_cnt), 32'd1);
    check("lock_latency", 32'(last_nv_cyc - last_rise_cyc), 32'd4);
    wave(10, 10, 20);
    check("steady_nv_cnt", 32'(nv_cnt), 32'd1);
    check("steady_ticks", 32'(ticks_a), 32'd10);

    // Jitter 20/21 stays locked
    for (int i = 0; i < 5; i++) begin
      wave(10, 10, 1);
      wave(10, 11, 1);
    end
    check("jitter_ticks", 32'(ticks_a), 32'd10);
    check("jitter_nv_cnt", 32'(nv_cnt), 32'd1);
    check("jitter_silent", 32'(silent_a), 32'd0);

    // Retune to P=30
    wave(15, 15, 3);
    check("retune_ticks", 32'(ticks_a), 32'd15);
    check("retune_nv_cnt", 32'(nv_cnt), 32'd2);
    wave(15, 15, 2);
    check("retune_hold_nv", 32'(nv_cnt), 32'd2);

    // P=40 then glitches
    wave(20, 20, 4);
    check("p40_ticks", 32'(ticks_a), 32'd20);
    check("p40_nv_cnt", 32'(nv_cnt), 32'd3);
    for (int i = 0; i < 3; i++) wave_glitch_early();
    check("glitch_early_ticks", 32'(ticks_a), 32'd20);
    check("glitch_early_nv", 32'(nv_cnt), 32'd3);
    for (int i = 0; i < 3; i++) wave_glitch_mid();
    check("glitch_mid_ticks", 32'(ticks_a), 32'd20);
    check("glitch_mid_silent", 32'(silent_a), 32'd0);
    check("glitch_mid_nv", 32'(nv_cnt), 32'd3);
    wave(20, 20, 3);
    check("relock_same_ticks", 32'(ticks_a), 32'd20);
    check("relock_same_nv", 32'(nv_cnt), 32'd3);

    // Silence
    tick(300);
    check("silence_silent", 32'(silent_a), 32'd1);
    check("silence_ticks", 32'(ticks_a), 32'd0);
    check("silence_nv_cnt", 32'(nv_cnt), 32'd4);
    check("silence_latency", 32'(last_nv_cyc - last_rise_cyc), 32'd204);
    tick(400);
    check("idle_nv_cnt", 32'(nv_cnt), 32'd4);

    // Rise exactly at cnt == TIMEOUT (P=200) keeps the lock
    wave(100, 100, 5);
    check("p200_ticks", 32'(ticks_a), 32'd100);
    check("p200_silent", 32'(silent_a), 32'd0);
    check("p200_nv_cnt", 32'(nv_cnt), 32'd5);
    tick(300);
    check("p200_timeout_silent", 32'(silent_a), 32'd1);
    check("p200_timeout_nv", 32'(nv_cnt), 32'd6);

    // P=399 on the long-timeout instance; short one keeps timing out silently
    wave(200, 199, 4);
    check("p399_ticks_b", 32'(ticks_b), 32'd199);
    check("p399_silent_b", 32'(silent_b), 32'd0);
    check("p399_silent_a", 32'(silent_a), 32'd1);
    check("p399_ticks_a", 32'(ticks_a), 32'd0);
    check("p399_nv_a", 32'(nv_cnt), 32'd6);

    // Reset mid-tone
    wave(10, 10, 3);
    check("pre_rst_ticks", 32'(ticks_a), 32'd10);
    check("pre_rst_nv", 32'(nv_cnt), 32'd7);
    sound_in = 1'b1;
    tick(5);
    clr = 1'b0;
    sound_in = 1'b0;
    #2;
    check("midrst_ticks", 32'(ticks_a), 32'd0);
    check("midrst_silent", 32'(silent_a), 32'd1);
    check("midrst_nv", 32'(nv_a), 32'd0);
    check("midrst_ticks_b", 32'(ticks_b), 32'd0);
    tick(3);
    clr = 1'b1;
    tick(3);
    wave(10, 10, 2);
    check("post_rst_nv", 32'(nv_cnt), 32'd7);
    check("post_rst_silent", 32'(silent_a), 32'd1);
    wave(10, 10, 1);
    check("post_rst_ticks", 32'(ticks_a), 32'd10);
    check("post_rst_lock_nv", 32'(nv_cnt), 32'd8);
    check("post_rst_latency", 32'(last_nv_cyc - last_rise_cyc), 32'd4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/tone_decoder.md
# tone_decoder

Receive-side counterpart to the square-wave note synthesiser. The block samples a one-bit square-wave input, measures its period in clock cycles and reports the equivalent half-period tick count, in the same 18-bit `ticks` units the song libraries use. It flags silence and pulses a strobe whenever the decoded note changes. It sits after an external or looped-back tone pin and feeds note-recognition and self-test logic.

## Interface
- `WIDTH`, 18: width of the `ticks` output; the internal period counter is `WIDTH+1` bits.
- `TOL`, 2: allowed absolute difference, in clocks, between consecutive periods for them to count as the same note.
- `MIN_PERIOD`, 4: a period shorter than this is a glitch.
- `TIMEOUT`, 400000: number of clocks with no accepted rising edge that declares silence; must be less than 2^(WIDTH+1).
- `clk`, input, 1: system clock; all logic is on the rising edge.
- `clr`, input, 1: asynchronous, active-low reset.
- `sound_in`, input, 1: asynchronous square-wave input.
- `ticks`, output, WIDTH: decoded half-period (period >> 1); 0 when silent.
- `silent`, output, 1: high when no tone is locked.
- `note_valid`, output, 1: one-cycle strobe when `ticks` or `silent` changes.

## Operation
- **Input conditioning.** `sound_in` passes through a 2-flop synchronizer, then a third register. A rising edge `rise` is flagged when sync=1 and the previous value was 0.
- **Period counter `cnt` (WIDTH+1 bits).**
  - On an accepted rise, `cnt` is loaded with 1.
  - Otherwise it increments, saturating at all-ones.
  - The measured period is P = `cnt` value in the cycle where the rise is flagged. Rises N clocks apart give P = N.
- **Glitch rule.** A rise with P < `MIN_PERIOD` is ignored: `cnt` keeps counting and the FSM does not react.
- **FSM states:** SILENT, ARM, CONFIRM, LOCKED. There is a candidate register `cand` (WIDTH+1 bits).
  - SILENT: `ticks`=0, `silent`=1. On any rise, clear `cnt` and go to ARM. The glitch rule is not applied in this state.
  - ARM: on an accepted rise, `cand`<=P and go to CONFIRM.
  - CONFIRM:
    - On an accepted rise with |P−`cand`| ≤ `TOL`: go to LOCKED, `ticks`<=P>>1, `silent`<=0, pulse `note_valid`.
    - Otherwise `cand`<=P and stay in CONFIRM.
    - `ticks` and `silent` keep their previous values while in this state.
  - LOCKED:
    - Matching rise: stay, with no strobe.
    - Non-matching accepted rise: `cand`<=P and go to CONFIRM; outputs hold the old note.
- **Re-lock.** Re-locking to a new period pulses `note_valid`. Re-locking to a period whose P>>1 equals the current `ticks` does not pulse it.
- **Timeout.** In ARM, CONFIRM or LOCKED, when `cnt` reaches `TIMEOUT` without an accepted rise:
  - go to SILENT, `ticks`<=0, `silent`<=1;
  - pulse `note_valid` only if `silent` was 0.
- **Simultaneous events.** A rise in the same cycle as the timeout is processed as a rise; the timeout is not taken.
- **Output formation.** `ticks` = P[WIDTH:1], i.e. an odd P truncates. No arithmetic overflows, because the timeout bounds P.

## Timing
- **Reset values:** state=SILENT, `ticks`=0, `silent`=1, `note_valid`=0, `cnt`=0, `cand`=0, all synchronizer flops 0.
- **Latency:** a `sound_in` edge reaches `rise` 3 clocks later. Outputs and `note_valid` update on the clock after the `rise` cycle, 4 clocks after the input edge.
- **Time to first lock:** at least 3 rising edges (ARM, CONFIRM, LOCKED).
- **Silence detection:** `silent` rises 1 clock after the cycle in which `cnt`=`TIMEOUT`.
- **Strobe:** `note_valid` is exactly 1 cycle wide, never asserted in two consecutive cycles, and never asserted without a change in `ticks`/`silent`.
- **Reset mid-measurement:** asserting `clr` mid-measurement aborts immediately. After release, the block needs 3 fresh edges to lock.

## Test plan
All scenarios use `TIMEOUT`=200 unless stated otherwise.
- **Reset:** assert `clr`=0 mid-tone → `ticks`=0, `silent`=1, `note_valid`=0 immediately; no strobe for 2 edges after release.
- **Basic lock:** square wave with half-period 10 (P=20) → after the 3rd rise, `ticks`=10, `silent`=0, one `note_valid` pulse 4 clocks after that edge; no further pulses over 20 periods.
- **Jitter and retune:**
  - Periods alternating 20/21 with `TOL`=2 → stays locked at `ticks`=10 with no strobes.
  - Switch to P=30 → after 2 periods, `ticks`=15 with one strobe.
- **Glitches:** 1-clock high glitches injected mid-period on a P=40 tone → `ticks` stays 20 and no strobe.
- **Silence:** stop the tone while locked → `silent`=1, `ticks`=0 and one strobe 201 clocks after the last rise; a further idle period produces no further strobe.
- **Boundary:** P=399 with `TIMEOUT`=400000 → `ticks`=199 (truncated). A rise arriving on the same cycle `cnt`=`TIMEOUT` → treated as a rise and no silence is declared.
